reg_mem_wb_mp: RTL and testbench
================================

# reg_mem_wb_mp

Parametrised multi-lane MEM/WB pipeline register for the wide-issue core: captures up to LANES writeback results per cycle from MEM under the common stall bus (Pass/Hold/Bubb), suppresses x0 and same-cycle duplicate destination writes, and keeps a 64-bit retired-instruction counter. Drives the register-file write ports; optional forwarding lookup serves the ID-stage bypass.

## Interface
- LANES, 2, writeback lanes (1..4); lane LANES-1 is youngest
- DW, 32, data width per lane
- AW, 5, register address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  `StallBus (2)  stage control: Pass, Hold, Bubb
- valid_i  in  LANES  lane k carries a retiring instruction
- rd_addr_i  in  LANES*AW  destination, lane k at [k*AW +: AW]
- rd_write_i  in  LANES  lane k writes rd
- rd_data_i  in  LANES*DW  write data, lane k at [k*DW +: DW]
- valid_o  out  LANES  registered valid
- rd_addr_o  out  LANES*AW  registered destination
- rd_write_o  out  LANES  filtered write enable
- rd_data_o  out  LANES*DW  registered data
- retired_o  out  64  retired-instruction count
- fwd_addr_i  in  AW  bypass lookup address
- fwd_hit_o  out  1  lookup hit
- fwd_data_o  out  DW  lookup data

## Operation
- Stall codes (shared config): Pass=2'b00, Hold=2'b01, Bubb=2'b10; 2'b11 treated as Hold.
- Pass: capture valid_i, rd_addr_i, rd_data_i per lane; rd_write_o[k] <= valid_i[k] & rd_write_i[k] & (rd_addr_i[k] != 0) & no lane j>k with valid_i[j] & rd_write_i[j] & rd_addr_i[j]==rd_addr_i[k]. Youngest lane wins duplicates.
- Hold: all registers keep value, counter unchanged.
- Bubb: valid_o, rd_addr_o, rd_write_o, rd_data_o cleared to 0; counter unchanged.
- Counter: on Pass, retired_o <= retired_o + popcount(valid_i); modulo 2^64 wrap. Invalid lanes with rd_write_i=1 count nothing and write nothing.
- Forwarding: combinational on registered outputs; hit if any lane k has rd_write_o[k] and rd_addr_o[k]==fwd_addr_i; data from highest such k; fwd_addr_i==0 never hits.

## Timing
- Reset: every output register and retired_o to 0 immediately on rst rise, independent of clk; reset mid-Hold discards held contents.
- Capture latency 1 cycle; outputs change only on clk edge or rst.
- Forward path is same-cycle from registered state; no input-to-output combinational path except fwd_addr_i -> fwd_*.
- Duplicate filtering and counter use the same-edge inputs; no cross-cycle dependency.

## Configuration
- WB_FWD_EN defined: forwarding lookup as above.
- WB_FWD_EN undefined: ports kept, fwd_hit_o and fwd_data_o tied 0, no comparators built.

## Structure
- StallBus width and Pass/Hold/Bubb codes live in the shared config header; no local redefinition.
- Sub-module wb_lane_filter: combinational LANES-way x0/duplicate suppression producing filtered write enables and popcount of valid_i.

## Test plan
- rst=1 mid-stream with nonzero state -> all outputs 0, retired_o=0 before next edge.
- LANES=2, Pass, lane0 {x5, 0x11}, lane1 {x5, 0x22}, both valid/write -> rd_write_o=2'b10, fwd_addr_i=5 gives hit, data 0x22, retired_o +2.
- Pass, lane0 write to x0, lane1 invalid with rd_write_i=1 -> rd_write_o=2'b00, retired_o +1.
- Pass load {x3, 0xAB}, then 3 cycles Hold with changing inputs -> outputs stay {x3, 0xAB}, counter unchanged; then Bubb -> all cleared, counter unchanged.
- Preload retired_o to 2^64-1 (force), Pass with 2 valid lanes -> retired_o=1.
- WB_FWD_EN undefined, matching address present -> fwd_hit_o=0, fwd_data_o=0.

Source files
------------

// File: rtl/reg_mem_wb_mp_pkg.sv
// Shared configuration for the MEM/WB pipeline register: stall bus encoding
// and counter widths used by the top level, the lane filter and the bench.
package reg_mem_wb_mp_pkg;

    localparam int STALL_W = 2;

    // Common stage-control bus; the spare code behaves like Hold.
    typedef enum logic [STALL_W-1:0] {
        STALL_PASS = 2'b00,
        STALL_HOLD = 2'b01,
        STALL_BUBB = 2'b10,
        STALL_RSVD = 2'b11
    } stall_bus_e;

    localparam int MAX_LANES = 4;
    localparam int CNT_W     = 3;   // holds popcount of up to MAX_LANES lanes
    localparam int RET_W     = 64;  // retired-instruction counter width

endpackage

// File: rtl/reg_mem_wb_mp_if.sv
// MEM/WB bus: MEM-side results and stall control in, registered writeback
// results, retired count and ID-stage bypass lookup out.
interface reg_mem_wb_mp_if #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    import reg_mem_wb_mp_pkg::*;

    stall_bus_e             stall;
    logic [LANES-1:0]       valid_i;
    logic [LANES*AW-1:0]    rd_addr_i;
    logic [LANES-1:0]       rd_write_i;
    logic [LANES*DW-1:0]    rd_data_i;
    logic [LANES-1:0]       valid_o;
    logic [LANES*AW-1:0]    rd_addr_o;
    logic [LANES-1:0]       rd_write_o;
    logic [LANES*DW-1:0]    rd_data_o;
    logic [RET_W-1:0]       retired_o;
    logic [AW-1:0]          fwd_addr_i;
    logic                   fwd_hit_o;
    logic [DW-1:0]          fwd_data_o;

    // Producer side (MEM stage / ID-stage bypass requester).
    modport master (
        output stall, valid_i, rd_addr_i, rd_write_i, rd_data_i, fwd_addr_i,
        input  valid_o, rd_addr_o, rd_write_o, rd_data_o, retired_o,
               fwd_hit_o, fwd_data_o
    );

    // Pipeline register side.
    modport slave (
        input  stall, valid_i, rd_addr_i, rd_write_i, rd_data_i, fwd_addr_i,
        output valid_o, rd_addr_o, rd_write_o, rd_data_o, retired_o,
               fwd_hit_o, fwd_data_o
    );

endinterface

// File: rtl/reg_mem_wb_mp_wb_lane_filter.sv
// wb_lane_filter: combinational write-enable filter for the MEM/WB lanes.
// Drops writes to x0 and any write shadowed by a younger lane targeting the
// same register in the same cycle; also counts the valid lanes.
module wb_lane_filter
    import reg_mem_wb_mp_pkg::*;
#(
    parameter int LANES = 2,
    parameter int AW    = 5
) (
    input  logic [LANES-1:0]    valid_i,
    input  logic [LANES*AW-1:0] rd_addr_i,
    input  logic [LANES-1:0]    rd_write_i,
    output logic [LANES-1:0]    wr_en_o,
    output logic [CNT_W-1:0]    count_o
);

    // Per lane: live write to a real register, cleared if any younger lane also writes it.
    always_comb begin
        wr_en_o = '0;
        count_o = '0;
        for (int k = 0; k < LANES; k++) begin
            count_o    = count_o + CNT_W'(valid_i[k]);
            wr_en_o[k] = valid_i[k] & rd_write_i[k] & (rd_addr_i[k*AW +: AW] != '0);
            for (int j = k + 1; j < LANES; j++) begin
                if (valid_i[j] && rd_write_i[j] &&
                    (rd_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
                    wr_en_o[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reg_mem_wb_mp.sv
// reg_mem_wb_mp: multi-lane MEM/WB pipeline register under the common stall
// bus, with filtered register-file write enables and a 64-bit retired counter.
// Define WB_FWD_EN to build the ID-stage bypass lookup; otherwise the lookup
// outputs are tied to zero and no comparators exist.
module reg_mem_wb_mp
    import reg_mem_wb_mp_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    reg_mem_wb_mp_if.slave    bus
);

    logic [LANES-1:0]    valid_d,   valid_q;
    logic [LANES*AW-1:0] addr_d,    addr_q;
    logic [LANES-1:0]    wr_d,      wr_q;
    logic [LANES*DW-1:0] data_d,    data_q;
    logic [RET_W-1:0]    retired_d, retired_q;

    logic [LANES-1:0]    filt_wr;
    logic [CNT_W-1:0]    lane_cnt;

    wb_lane_filter #(
        .LANES (LANES),
        .AW    (AW)
    ) u_filter (
        .valid_i    (bus.valid_i),
        .rd_addr_i  (bus.rd_addr_i),
        .rd_write_i (bus.rd_write_i),
        .wr_en_o    (filt_wr),
        .count_o    (lane_cnt)
    );

    // Next state from the stall code: Pass captures, Bubb clears results, anything else holds.
    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        data_d    = data_q;
        retired_d = retired_q;
        case (bus.stall)
            STALL_PASS: begin
                valid_d   = bus.valid_i;
                addr_d    = bus.rd_addr_i;
                wr_d      = filt_wr;
                data_d    = bus.rd_data_i;
                retired_d = retired_q + RET_W'(lane_cnt);
            end
            STALL_BUBB: begin
                valid_d = '0;
                addr_d  = '0;
                wr_d    = '0;
                data_d  = '0;
            end
            default: ;
        endcase
    end

    // Stage register; reset clears everything at once, including held contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            addr_q    <= '0;
            wr_q      <= '0;
            data_q    <= '0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            retired_q <= retired_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.rd_addr_o  = addr_q;
    assign bus.rd_write_o = wr_q;
    assign bus.rd_data_o  = data_q;
    assign bus.retired_o  = retired_q;

`ifdef WB_FWD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    // Bypass lookup on registered state; later (younger) lanes override older matches.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (wr_q[k] && (bus.fwd_addr_i != '0) &&
                (addr_q[k*AW +: AW] == bus.fwd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[k*DW +: DW];
            end
        end
    end

    assign bus.fwd_hit_o  = fwd_hit;
    assign bus.fwd_data_o = fwd_data;
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^bus.fwd_addr_i;
    assign bus.fwd_hit_o   = 1'b0;
    assign bus.fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_reg_mem_wb_mp.sv
// Bench for reg_mem_wb_mp (LANES=2): expected register contents are pushed to
// a scoreboard queue as each cycle is driven and popped after the edge.
// Forwarding expectations follow WB_FWD_EN.
module tb_reg_mem_wb_mp;
    import reg_mem_wb_mp_pkg::*;

    localparam int L  = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [L-1:0]    valid;
        logic [L*AW-1:0] addr;
        logic [L-1:0]    wr;
        logic [L*DW-1:0] data;
        logic [63:0]     retired;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_mem_wb_mp_if #(.LANES(L), .DW(DW), .AW(AW)) bus ();

    reg_mem_wb_mp #(.LANES(L), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t m;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic exp_t obs();
        return {bus.valid_o, bus.rd_addr_o, bus.rd_write_o, bus.rd_data_o, bus.retired_o};
    endfunction

    // Expected {hit, data}: youngest writing lane with matching nonzero address.
    function automatic logic [DW:0] fwd_model(input logic [AW-1:0] f);
        logic [DW:0] r;
        r = '0;
`ifdef WB_FWD_EN
        for (int k = L - 1; k >= 0; k--) begin
            if (r[DW] == 1'b0 && f != '0 && m.wr[k] && m.addr[k*AW +: AW] == f) begin
                r = {1'b1, m.data[k*DW +: DW]};
            end
        end
`endif
        return r;
    endfunction

    // Drive one cycle of MEM inputs, advance the model, push expectation, wait past the edge.
    task automatic drive(input logic [1:0] st, input logic [L-1:0] v,
                         input logic [L*AW-1:0] a, input logic [L-1:0] w,
                         input logic [L*DW-1:0] d);
        logic [31:0]   claimed;
        logic [AW-1:0] ak;
        @(negedge clk);
        bus.stall      = stall_bus_e'(st);
        bus.valid_i    = v;
        bus.rd_addr_i  = a;
        bus.rd_write_i = w;
        bus.rd_data_i  = d;
        if (st == 2'b00) begin
            claimed = '0;
            m.wr    = '0;
            for (int k = L - 1; k >= 0; k--) begin
                ak = a[k*AW +: AW];
                if (v[k] && w[k] && ak != '0 && !claimed[ak]) begin
                    m.wr[k]     = 1'b1;
                    claimed[ak] = 1'b1;
                end
            end
            m.valid   = v;
            m.addr    = a;
            m.data    = d;
            m.retired = m.retired + 64'($countones(v));
        end else if (st == 2'b10) begin
            m.valid = '0;
            m.addr  = '0;
            m.wr    = '0;
            m.data  = '0;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h want 0", obs());
        end
        checks++;
        if (bus.fwd_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_fwd: got %b want 0", bus.fwd_hit_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dup();
        exp_t e;
        logic [DW:0] want;
        drive(2'b00, 2'b11, {5'd5, 5'd5}, 2'b11, {32'h22, 32'h11});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL dup_out: got %h want %h", obs(), e);
        end
        checks++;
        if (bus.rd_write_o !== 2'b10 || bus.retired_o !== 64'd2) begin
            errors++;
            $display("FAIL dup_wr: got wr=%b ret=%0d want wr=10 ret=2", bus.rd_write_o, bus.retired_o);
        end
        bus.fwd_addr_i = 5'd5;
        #1;
`ifdef WB_FWD_EN
        want = {1'b1, 32'h22};
`else
        want = '0;
`endif
        checks++;
        if ({bus.fwd_hit_o, bus.fwd_data_o} !== want) begin
            errors++;
            $display("FAIL dup_fwd: got %b/%h want %h", bus.fwd_hit_o, bus.fwd_data_o, want);
        end
    endtask

    task automatic test_x0();
        exp_t e;
        drive(2'b00, 2'b01, {5'd9, 5'd0}, 2'b11, {32'h99, 32'h55});
        e = sb.pop_front();
        checks++;
        if (obs() !== e || bus.rd_write_o !== 2'b00) begin
            errors++;
            $display("FAIL x0_out: got %h want %h", obs(), e);
        end
        for (int f = 0; f < 10; f += 9) begin
            bus.fwd_addr_i = AW'(f);
            #1;
            checks++;
            if ({bus.fwd_hit_o, bus.fwd_data_o} !== 33'd0) begin
                errors++;
                $display("FAIL x0_fwd%0d: got %b/%h want 0", f, bus.fwd_hit_o, bus.fwd_data_o);
            end
        end
    endtask

    task automatic test_hold_bubb();
        exp_t e;
        drive(2'b00, 2'b01, {5'd0, 5'd3}, 2'b01, {32'h0, 32'hAB});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL load_out: got %h want %h", obs(), e);
        end
        for (int i = 0; i < 3; i++) begin
            drive((i == 1) ? 2'b11 : 2'b01, 2'b11, {5'(i + 7), 5'(i + 12)}, 2'b11,
                  {32'($urandom), 32'($urandom)});
            e = sb.pop_front();
            checks++;
            if (obs() !== e || bus.rd_addr_o[AW-1:0] !== 5'd3 || bus.rd_data_o[DW-1:0] !== 32'hAB) begin
                errors++;
                $display("FAIL hold%0d_out: got %h want %h", i, obs(), e);
            end
        end
        drive(2'b10, 2'b11, {5'd1, 5'd2}, 2'b11, {32'h1, 32'h2});
        e = sb.pop_front();
        checks++;
        if (obs() !== e || bus.valid_o !== 2'b00 || bus.rd_data_o !== '0) begin
            errors++;
            $display("FAIL bubb_out: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_fwd();
        exp_t e;
        logic [DW:0] want;
        drive(2'b00, 2'b11, {5'd6, 5'd4}, 2'b11, {32'h66, 32'h44});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL fwd_load: got %h want %h", obs(), e);
        end
        for (int f = 4; f <= 7; f++) begin
            bus.fwd_addr_i = AW'(f);
            #1;
            want = fwd_model(AW'(f));
            checks++;
            if ({bus.fwd_hit_o, bus.fwd_data_o} !== want) begin
                errors++;
                $display("FAIL fwd_x%0d: got %b/%h want %h", f, bus.fwd_hit_o, bus.fwd_data_o, want);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        force dut.retired_d = 64'hFFFF_FFFF_FFFF_FFFF;
        m.retired = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(2'b00, 2'b00, '0, '0, '0);
        release dut.retired_d;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL wrap_preload: got %h want %h", obs(), e);
        end
        drive(2'b00, 2'b11, {5'd2, 5'd1}, 2'b11, {32'h2, 32'h1});
        e = sb.pop_front();
        checks++;
        if (obs() !== e || bus.retired_o !== 64'd1) begin
            errors++;
            $display("FAIL wrap_out: got ret=%0d want 1", bus.retired_o);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [1:0]  st;
        logic [DW:0] want;
        int r;
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            st = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            drive(st, L'($urandom), {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                  L'($urandom), {32'($urandom), 32'($urandom)});
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL b2b%0d_out: got %h want %h", i, obs(), e);
            end
            bus.fwd_addr_i = AW'($urandom_range(0, 3));
            #1;
            want = fwd_model(bus.fwd_addr_i);
            checks++;
            if ({bus.fwd_hit_o, bus.fwd_data_o} !== want) begin
                errors++;
                $display("FAIL b2b%0d_fwd: got %b/%h want %h", i, bus.fwd_hit_o, bus.fwd_data_o, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(2'b00, 2'b11, {5'd8, 5'd7}, 2'b11, {32'h88, 32'h77});
        e = sb.pop_front();
        drive(2'b01, 2'b11, {5'd1, 5'd1}, 2'b11, {32'h5, 32'h6});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL pre_rst_out: got %h want %h", obs(), e);
        end
        #1;
        rst = 1'b1;
        bus.fwd_addr_i = 5'd7;
        #1;
        m = '0;
        sb.delete();
        checks++;
        if (obs() !== '0 || bus.fwd_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out: got %h hit=%b want 0", obs(), bus.fwd_hit_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 2'b11, {5'd3, 5'd3}, 2'b11, {32'h3, 32'h3});
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL post_rst_hold: got %h want %h", obs(), e);
        end
    endtask

    initial begin
        m              = '0;
        bus.stall      = STALL_PASS;
        bus.valid_i    = '0;
        bus.rd_addr_i  = '0;
        bus.rd_write_i = '0;
        bus.rd_data_i  = '0;
        bus.fwd_addr_i = '0;
        test_reset();
        test_dup();
        test_x0();
        test_hold_bubb();
        test_fwd();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
